// File: rtl/mdu_pkg.sv
// Shared types and constants for the HI/LO multiply/divide unit and its divider.
package mdu_pkg;

  typedef logic [31:0] int_t;

  typedef enum logic [2:0] {
    MULT,
    MULTU,
    DIV,
    DIVU,
    MFHI,
    MFLO,
    MTHI,
    MTLO
  } mdu_op_t;

  typedef enum logic [1:0] {
    IDLE,
    MULTIPLYING,
    DIVIDING
  } mdu_state_t;

  localparam int   DIVIDE_ITERATIONS = 32;
  // Divide by zero yields all-ones quotient; the remainder is the dividend itself.
  localparam int_t DIV_ZERO_QUOTIENT = 32'hFFFF_FFFF;

endpackage

// File: rtl/iterative_divider.sv
// Unsigned 32/32 restoring divider, one quotient bit per cycle; done rises 32 cycles after start.
// No backpressure: start is only pulsed by the owner while idle, results hold while done is high.
module iterative_divider
  import mdu_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic start,
  input  int_t dividend,
  input  int_t divisor,
  output logic done,
  output int_t quotient,
  output int_t remainder
);

  int_t       rem;
  int_t       quo;
  int_t       den;
  logic [5:0] cnt;
  logic       active;
  logic [32:0] shifted;
  logic        fits;
  int_t        rem_next;

  // Partial remainder is below den, so the 32-bit wrapped difference is exact when it fits.
  always_comb begin
    shifted  = {rem, quo[31]};
    fits     = shifted >= {1'b0, den};
    rem_next = fits ? (shifted[31:0] - den) : shifted[31:0];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rem    <= '0;
      quo    <= '0;
      den    <= '0;
      cnt    <= '0;
      active <= 1'b0;
    end else if (start) begin
      rem    <= '0;
      quo    <= dividend;
      den    <= divisor;
      cnt    <= 6'(DIVIDE_ITERATIONS);
      active <= 1'b1;
    end else if (active) begin
      if (cnt != '0) begin
        rem <= rem_next;
        quo <= {quo[30:0], fits};
        cnt <= cnt - 6'd1;
      end else begin
        active <= 1'b0;
      end
    end
  end

  assign done      = active && (cnt == '0);
  assign quotient  = quo;
  assign remainder = rem;

endmodule

// File: rtl/multiply_divide_controller.sv
// HI/LO unit: MULT/MULTU busy MULT_LATENCY cycles, DIV/DIVU 33 (1 on /0), MTHI/MTLO/MFHI/MFLO none.
// Any op presented while busy is stalled; DIVIDER_EN includes the divider, otherwise DIV/DIVU write zeros.
module multiply_divide_controller
  import mdu_pkg::*;
#(
  parameter int MULT_LATENCY = 4
) (
  input  logic    clock,
  input  logic    reset,
  input  logic    opValid,
  input  mdu_op_t op,
  input  int_t    operandA,
  input  int_t    operandB,
  output logic    stall,
  output int_t    result,
  output logic    resultValid,
  output int_t    hi,
  output int_t    lo
);

  mdu_state_t  state;
  mdu_state_t  state_next;
  logic [3:0]  counter;
  logic [63:0] product;
  logic [63:0] mult_product;
  logic        busy;
  logic        accept;
  logic        is_mult;
  logic        is_div;
  logic        div_finish;
  int_t        div_hi;
  int_t        div_lo;

  always_comb begin
    busy        = state != IDLE;
    stall       = opValid && busy && !reset;
    accept      = opValid && !busy && !reset;
    is_mult     = (op == MULT) || (op == MULTU);
    is_div      = (op == DIV) || (op == DIVU);
    result      = '0;
    resultValid = 1'b0;
    if (accept && (op == MFHI || op == MFLO)) begin
      resultValid = 1'b1;
      result      = (op == MFHI) ? hi : lo;
    end
  end

  // Sign-extending for MULT lets one 64-bit multiplier serve both signednesses.
  always_comb begin
    mult_product = {(op == MULT) ? {32{operandA[31]}} : 32'h0, operandA}
                 * {(op == MULT) ? {32{operandB[31]}} : 32'h0, operandB};
  end

`ifdef DIVIDER_EN
  logic q_neg_q;
  logic r_neg_q;
  logic div_zero_q;
  int_t zero_rem_q;
  int_t mag_a;
  int_t mag_b;
  int_t div_quo;
  int_t div_rem;
  logic div_start;
  logic div_done;

  always_comb begin
    mag_a     = (op == DIV && operandA[31]) ? -operandA : operandA;
    mag_b     = (op == DIV && operandB[31]) ? -operandB : operandB;
    div_start = accept && is_div && (operandB != '0);
  end

  iterative_divider u_divider (
    .clock     (clock),
    .reset     (reset),
    .start     (div_start),
    .dividend  (mag_a),
    .divisor   (mag_b),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      q_neg_q    <= 1'b0;
      r_neg_q    <= 1'b0;
      div_zero_q <= 1'b0;
      zero_rem_q <= '0;
    end else if (accept && is_div) begin
      q_neg_q    <= (op == DIV) && (operandA[31] ^ operandB[31]);
      r_neg_q    <= (op == DIV) && operandA[31];
      div_zero_q <= operandB == '0;
      zero_rem_q <= operandA;
    end
  end

  // Sign fixup happens in the cycle the divider reports done.
  always_comb begin
    div_finish = div_zero_q || div_done;
    div_lo     = div_zero_q ? DIV_ZERO_QUOTIENT : (q_neg_q ? -div_quo : div_quo);
    div_hi     = div_zero_q ? zero_rem_q : (r_neg_q ? -div_rem : div_rem);
  end
`else
  always_comb begin
    div_finish = 1'b1;
    div_lo     = '0;
    div_hi     = '0;
  end
`endif

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept && is_mult)     state_next = MULTIPLYING;
        else if (accept && is_div) state_next = DIVIDING;
      end
      MULTIPLYING: if (counter == '0) state_next = IDLE;
      DIVIDING:    if (div_finish)    state_next = IDLE;
      default:     state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      hi      <= '0;
      lo      <= '0;
      counter <= '0;
      product <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            case (op)
              MULT, MULTU: begin
                product <= mult_product;
                counter <= 4'(MULT_LATENCY - 1);
              end
              MTHI:    hi <= operandA;
              MTLO:    lo <= operandA;
              default: ;
            endcase
          end
        end
        MULTIPLYING: begin
          if (counter == '0) {hi, lo} <= product;
          else               counter  <= counter - 4'd1;
        end
        DIVIDING: begin
          if (div_finish) begin
            hi <= div_hi;
            lo <= div_lo;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
